// File: rtl/vv_fb_writer.sv
// rtl/vv_fb_writer.sv - double-buffered write side of the monochrome video memory
module vv_fb_writer #(
    parameter int COLS             = 10,
    parameter int ROWS             = 10,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_x,
    input  logic [3:0]             cmd_y,
    input  logic                   cmd_pixel,
    input  logic                   vsync,
    output logic [COLS*ROWS-1:0]   video_memory,
    output logic [7:0]             frame_count,
    output logic                   cmd_err
);

    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);

    // Level of vsync outside the sync pulse
    localparam logic VS_INACTIVE = (VSYNC_ACTIVE_LOW != 0);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COMMIT_WAIT
    } state_t;

    state_t          state;
    logic [N-1:0]    back;
    logic [IW-1:0]   clr_cnt;
    logic            vs_s1, vs_s2, vs_s3;
    logic            vs_edge;
    logic            in_range;
    logic [IW-1:0]   wr_idx;

    // Range is judged on the raw 4-bit coordinates so an out-of-range x can
    // never alias onto the next row after the multiply.
    assign in_range = (int'(cmd_x) < COLS) && (int'(cmd_y) < ROWS);
    assign wr_idx   = IW'(cmd_y) * IW'(COLS) + IW'(cmd_x);

    // Start of the sync pulse: synchronised vsync just became active
    assign vs_edge  = (vs_s2 != VS_INACTIVE) && (vs_s3 == VS_INACTIVE);

    // Two-flop synchroniser plus one history flop for edge detection; runs in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= VS_INACTIVE;
            vs_s2 <= VS_INACTIVE;
            vs_s3 <= VS_INACTIVE;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    // Command FSM owning back buffer, front buffer, frame counter and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            cmd_err      <= 1'b0;
            back         <= '0;
            video_memory <= '0;
            frame_count  <= 8'd0;
            clr_cnt      <= '0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                if (in_range) begin
                                    back[wr_idx] <= cmd_pixel;
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                state     <= CLEAR;
                                cmd_ready <= 1'b0;
                                clr_cnt   <= '0;
                            end
                            OP_COMMIT: begin
                                state     <= COMMIT_WAIT;
                                cmd_ready <= 1'b0;
                            end
                            default: begin
                                cmd_err <= 1'b1;
                            end
                        endcase
                    end
                end
                CLEAR: begin
                    back[clr_cnt] <= 1'b0;
                    if (clr_cnt == IW'(N - 1)) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                COMMIT_WAIT: begin
                    // Back buffer is kept so drawing continues from the published image
                    if (vs_edge) begin
                        video_memory <= back;
                        frame_count  <= frame_count + 8'd1;
                        state        <= IDLE;
                        cmd_ready    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vv_fb_writer.sv
// tb/tb_vv_fb_writer.sv - directed self-checking bench for vv_fb_writer
module tb_vv_fb_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [3:0]   cmd_x;
    logic [3:0]   cmd_y;
    logic         cmd_pixel;
    logic         vsync;
    logic [99:0]  video_memory;
    logic [7:0]   frame_count;
    logic         cmd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic       pix;
        logic       err;
        int         idx;
    } vec_t;

    vec_t vt[12];

    vv_fb_writer #(.COLS(10), .ROWS(10), .VSYNC_ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_pixel    (cmd_pixel),
        .vsync        (vsync),
        .video_memory (video_memory),
        .frame_count  (frame_count),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready, then presents one command for one edge
    task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                        input logic pix);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout actual=0 expected=1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_pixel = pix;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic vsync_pulse(input int low_cycles, input int high_cycles);
        @(negedge clk);
        vsync = 1'b0;
        repeat (low_cycles) @(negedge clk);
        vsync = 1'b1;
        repeat (high_cycles) @(negedge clk);
    endtask

    initial begin
        logic [127:0] e;
        logic [127:0] b11;
        int           n;

        vt[0]  = '{op: 2'd0, x: 4'd3,  y: 4'd2,  pix: 1'b1, err: 1'b0, idx: 23};
        vt[1]  = '{op: 2'd0, x: 4'd10, y: 4'd0,  pix: 1'b1, err: 1'b1, idx: -1};
        vt[2]  = '{op: 2'd0, x: 4'd0,  y: 4'd10, pix: 1'b1, err: 1'b1, idx: -1};
        vt[3]  = '{op: 2'd0, x: 4'd9,  y: 4'd9,  pix: 1'b1, err: 1'b0, idx: 99};
        vt[4]  = '{op: 2'd0, x: 4'd0,  y: 4'd0,  pix: 1'b1, err: 1'b0, idx: 0};
        vt[5]  = '{op: 2'd3, x: 4'd0,  y: 4'd0,  pix: 1'b0, err: 1'b1, idx: -1};
        vt[6]  = '{op: 2'd0, x: 4'd15, y: 4'd15, pix: 1'b1, err: 1'b1, idx: -1};
        vt[7]  = '{op: 2'd0, x: 4'd9,  y: 4'd0,  pix: 1'b1, err: 1'b0, idx: 9};
        vt[8]  = '{op: 2'd0, x: 4'd0,  y: 4'd9,  pix: 1'b1, err: 1'b0, idx: 90};
        vt[9]  = '{op: 2'd0, x: 4'd5,  y: 4'd5,  pix: 1'b1, err: 1'b0, idx: 55};
        vt[10] = '{op: 2'd0, x: 4'd5,  y: 4'd5,  pix: 1'b0, err: 1'b0, idx: 55};
        vt[11] = '{op: 2'd0, x: 4'd7,  y: 4'd1,  pix: 1'b1, err: 1'b0, idx: 17};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_x     = 4'd0;
        cmd_y     = 4'd0;
        cmd_pixel = 1'b0;
        vsync     = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_video", video_memory, 0);
        chk("reset_fc", frame_count, 0);
        chk("reset_err", cmd_err, 0);
        chk("reset_ready", cmd_ready, 1);

        // Write does not reach the display until a commit lands on vsync
        send(2'd0, 4'd3, 4'd2, 1'b1);
        repeat (3) @(negedge clk);
        chk("write_not_visible", video_memory, 0);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("commit_ready_low", cmd_ready, 0);
        vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("commit_before_3rd_edge", video_memory, 0);
        @(negedge clk);
        e = 0; e[23] = 1'b1;
        chk("commit_pix23", video_memory, e);
        chk("commit_fc1", frame_count, 1);
        chk("commit_ready_back", cmd_ready, 1);
        vsync = 1'b1;
        repeat (3) @(negedge clk);

        // Table of writes: cmd_err per vector, then one commit reveals the back buffer
        e = 0; e[23] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vt[i].op, vt[i].x, vt[i].y, vt[i].pix);
            @(negedge clk);
            chk($sformatf("vec%0d_err", i), cmd_err, vt[i].err);
            @(negedge clk);
            chk($sformatf("vec%0d_err_clear", i), cmd_err, 0);
            if (vt[i].idx >= 0) e[vt[i].idx] = vt[i].pix;
        end
        chk("table_front_unchanged", video_memory, 128'h800000);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        vsync_pulse(4, 3);
        chk("table_front", video_memory, e);
        chk("table_fc2", frame_count, 2);

        // Fill every pixel, publish, then clear while watching cmd_ready
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                send(2'd0, 4'(x), 4'(y), 1'b1);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        vsync_pulse(4, 3);
        chk("fill_all_ones", video_memory, {28'd0, {100{1'b1}}});
        chk("fill_fc3", frame_count, 3);
        send(2'd1, 4'd0, 4'd0, 1'b0);
        n = 0;
        vsync = 1'b0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            n++;
            if (n == 50) vsync = 1'b1;
            @(negedge clk);
        end
        chk("clear_ready_low_cycles", n, 100);
        chk("clear_front_kept", video_memory, {28'd0, {100{1'b1}}});
        chk("clear_vsync_ignored_fc", frame_count, 3);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        vsync_pulse(4, 3);
        chk("clear_commit_zero", video_memory, 0);
        chk("clear_commit_fc4", frame_count, 4);

        // vsync with nothing pending changes nothing
        for (int i = 0; i < 5; i++) vsync_pulse(3, 3);
        chk("idle_vsync_video", video_memory, 0);
        chk("idle_vsync_fc", frame_count, 4);

        // Commit accepted while vsync already active waits for a fresh edge
        send(2'd0, 4'd1, 4'd1, 1'b1);
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        repeat (6) @(negedge clk);
        chk("low_commit_no_update", video_memory, 0);
        chk("low_commit_fc_hold", frame_count, 4);
        chk("low_commit_waiting", cmd_ready, 0);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        chk("low_commit_rise_no_update", frame_count, 4);
        vsync_pulse(4, 3);
        b11 = 0; b11[11] = 1'b1;
        chk("low_commit_video", video_memory, b11);
        chk("low_commit_fc5", frame_count, 5);
        vsync_pulse(4, 3);
        chk("low_commit_single_update", frame_count, 5);

        // Asynchronous reset in the middle of a clear
        send(2'd1, 4'd0, 4'd0, 1'b0);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clear_video", video_memory, 0);
        chk("rst_clear_fc", frame_count, 0);
        chk("rst_clear_err", cmd_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_clear_ready", cmd_ready, 1);

        // Asynchronous reset while waiting for vsync aborts the commit
        send(2'd0, 4'd2, 4'd2, 1'b1);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        vsync_pulse(4, 3);
        e = 0; e[22] = 1'b1;
        chk("pre_rst_video", video_memory, e);
        chk("pre_rst_fc", frame_count, 1);
        send(2'd2, 4'd0, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("rst_wait_ready_low", cmd_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_video", video_memory, 0);
        chk("rst_wait_fc", frame_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wait_ready", cmd_ready, 1);
        vsync_pulse(4, 3);
        chk("rst_wait_aborted_fc", frame_count, 0);

        // frame_count wraps after 256 commits
        for (int i = 0; i < 256; i++) begin
            send(2'd2, 4'd0, 4'd0, 1'b0);
            vsync_pulse(4, 3);
            if (i == 0) chk("wrap_first", frame_count, 1);
            if (i == 254) chk("wrap_255", frame_count, 255);
        end
        chk("wrap_zero", frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
